// File: rtl/adc_rx_pkg.sv
// adc_rx_pkg
// Shared definitions for the serial ADC frame receiver:
//   - adc_state_e      : receiver FSM state encoding
//   - DEF_*            : default parameter values used by the modules
//   - bit_cnt_w()      : width of the in-frame bit counter
//   - quiet_cnt_w()    : width of the inter-frame quiet counter
package adc_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_QUIET = 2'd2
    } adc_state_e;

    localparam int DEF_NCH       = 2;
    localparam int DEF_DATA_W    = 12;
    localparam int DEF_FRAME_LEN = 16;
    localparam int DEF_LEAD      = 4;
    localparam int DEF_QUIET     = 2;

    // Bit counter spans 0..FRAME_LEN-1; kept at least 1 bit wide so a
    // degenerate one-bit frame still elaborates.
    function automatic int bit_cnt_w(input int frame_len);
        if (frame_len <= 1) begin
            return 1;
        end
        return $clog2(frame_len);
    endfunction

    // Quiet counter spans 0..QUIET-1 with one bit of headroom.
    function automatic int quiet_cnt_w(input int quiet);
        return $clog2(quiet) + 1;
    endfunction

endpackage

// File: rtl/adc_shift_lane.sv
// adc_shift_lane
// One ADC data line: a DATA_W-bit MSB-first shift register and a sticky
// lead-error bit that records any 1 seen in the leading bit positions.
// The next-state values are exported so the top level can capture a frame
// that includes the bit sampled on the final edge.
//
// Ports:
//   sclk       in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   bit_idx    in   index of the bit sampled on this edge
//   sample_en  in   sdata is a frame bit on this edge
//   clr        in   frame complete: clear register and lead error
//   sdata      in   serial data for this lane
//   data_nxt   out  shift register value after this edge's sample
//   lead_nxt   out  lead-error value after this edge's sample
module adc_shift_lane
    import adc_rx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEAD   = DEF_LEAD,
    parameter int IDX_W  = bit_cnt_w(DEF_FRAME_LEN)
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  bit_idx,
    input  logic              sample_en,
    input  logic              clr,
    input  logic              sdata,
    output logic [DATA_W-1:0] data_nxt,
    output logic              lead_nxt
);

    logic [DATA_W-1:0] shift_q;
    logic              lead_q;
    logic [DATA_W-1:0] shifted;
    logic              in_lead;
    logic              in_data;

    assign in_lead = int'(bit_idx) < LEAD;
    assign in_data = (int'(bit_idx) >= LEAD) && (int'(bit_idx) < LEAD + DATA_W);

    generate
        if (DATA_W == 1) begin : g_one_bit
            assign shifted = sdata;
        end else begin : g_multi_bit
            assign shifted = {shift_q[DATA_W-2:0], sdata};
        end
    endgenerate

    assign data_nxt = (sample_en && in_data) ? shifted : shift_q;
    assign lead_nxt = lead_q | (sample_en & in_lead & sdata);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            lead_q  <= 1'b0;
        end else if (clr) begin
            shift_q <= '0;
            lead_q  <= 1'b0;
        end else begin
            shift_q <= data_nxt;
            lead_q  <= lead_nxt;
        end
    end

endmodule

// File: rtl/adc_serial_rx.sv
// adc_serial_rx
// Multi-channel SPI-style ADC frame receiver. Drives a shared chip select,
// samples NCH data lines for FRAME_LEN cycles, strips and checks LEAD
// leading bits, and presents DATA_W bits per channel in a valid/ready
// holding register with a sticky overrun flag. Single-shot on start, or
// back-to-back frames while cont is high.
//
// Ports:
//   sclk       in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle request for a single frame (IDLE only)
//   cont       in   continuous mode, frames repeat while high
//   sdata      in   serial data, channel i on bit i
//   cs_n       out  ADC chip select, active low, registered
//   dout       out  channel i sample at dout[i*DATA_W +: DATA_W]
//   valid      out  dout holds an unconsumed sample set
//   ready      in   consumer accepts dout when valid && ready
//   overrun    out  sticky: an unconsumed sample set was overwritten
//   frame_err  out  latest frame had a nonzero leading bit
//   busy       out  FSM not in IDLE
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | cs_n high, waiting for start or cont
// S_SHIFT | cs_n low, sampling one frame bit per edge
// S_QUIET | cs_n high for QUIET cycles before the next frame or IDLE
module adc_serial_rx
    import adc_rx_pkg::*;
#(
    parameter int NCH       = DEF_NCH,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int LEAD      = DEF_LEAD,
    parameter int QUIET     = DEF_QUIET
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cont,
    input  logic [NCH-1:0]        sdata,
    output logic                  cs_n,
    output logic [NCH*DATA_W-1:0] dout,
    output logic                  valid,
    input  logic                  ready,
    output logic                  overrun,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int BCW = bit_cnt_w(FRAME_LEN);
    localparam int QCW = quiet_cnt_w(QUIET);

    localparam logic [BCW-1:0] BIT_LAST   = BCW'(FRAME_LEN - 1);
    localparam logic [QCW-1:0] QUIET_LAST = QCW'(QUIET - 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_QUIET = ST_QUIET;

    logic [1:0]            state;
    logic [BCW-1:0]        bit_cnt;
    logic [QCW-1:0]        quiet_cnt;
    logic                  sample_en;
    logic                  frame_done;
    logic                  accept;
    logic [NCH*DATA_W-1:0] data_nxt;
    logic [NCH-1:0]        lead_nxt;

    assign sample_en  = (state == S_SHIFT);
    assign frame_done = sample_en && (bit_cnt == BIT_LAST);
    assign accept     = valid && ready;
    assign busy       = (state != S_IDLE);

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_lane
            adc_shift_lane #(
                .DATA_W (DATA_W),
                .LEAD   (LEAD),
                .IDX_W  (BCW)
            ) u_lane (
                .sclk      (sclk),
                .rst       (rst),
                .bit_idx   (bit_cnt),
                .sample_en (sample_en),
                .clr       (frame_done),
                .sdata     (sdata[i]),
                .data_nxt  (data_nxt[i*DATA_W +: DATA_W]),
                .lead_nxt  (lead_nxt[i])
            );
        end
    endgenerate

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cs_n      <= 1'b1;
            bit_cnt   <= '0;
            quiet_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start || cont) begin
                        state   <= S_SHIFT;
                        cs_n    <= 1'b0;
                        bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt == BIT_LAST) begin
                        state     <= S_QUIET;
                        cs_n      <= 1'b1;
                        quiet_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_QUIET: begin
                    if (quiet_cnt == QUIET_LAST) begin
                        // cont is re-evaluated here, so dropping it mid-frame
                        // still lets the current frame and its quiet time finish.
                        if (cont) begin
                            state   <= S_SHIFT;
                            cs_n    <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        quiet_cnt <= quiet_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cs_n  <= 1'b1;
                end
            endcase
        end
    end

    // Frame completion wins over a plain accept; an accept on the same edge
    // only clears overrun while the fresh sample set stays valid.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            dout      <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else if (frame_done) begin
            dout      <= data_nxt;
            frame_err <= |lead_nxt;
            valid     <= 1'b1;
            if (valid) begin
                overrun <= !ready;
            end
        end else if (accept) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_serial_rx.sv
module tb_adc_serial_rx;

    localparam int NCH       = 2;
    localparam int DATA_W    = 12;
    localparam int FRAME_LEN = 16;
    localparam int LEAD      = 4;
    localparam int QUIET     = 2;

    typedef logic [NCH*FRAME_LEN-1:0] fset_t;
    typedef logic [NCH*DATA_W-1:0]    dset_t;

    logic              sclk;
    logic              rst;
    logic              start;
    logic              cont;
    logic [NCH-1:0]    sdata;
    logic              cs_n;
    dset_t             dout;
    logic              valid;
    logic              ready;
    logic              overrun;
    logic              frame_err;
    logic              busy;

    int checks = 0;
    int errors = 0;

    fset_t adc_q[$];

    adc_serial_rx #(
        .NCH       (NCH),
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .LEAD      (LEAD),
        .QUIET     (QUIET)
    ) dut (
        .sclk      (sclk),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
        .sdata     (sdata),
        .cs_n      (cs_n),
        .dout      (dout),
        .valid     (valid),
        .ready     (ready),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    // ADC model: while cs_n is low, present one frame bit per falling edge,
    // MSB first; a new frame word is taken from adc_q at the first bit.
    initial begin
        fset_t cur;
        int    bit_i;
        cur   = '0;
        bit_i = 0;
        sdata = '0;
        forever begin
            @(negedge sclk);
            if (cs_n === 1'b0) begin
                if (bit_i == 0) begin
                    if (adc_q.size() > 0) cur = adc_q.pop_front();
                    else cur = '0;
                end
                if (bit_i < FRAME_LEN) begin
                    for (int ch = 0; ch < NCH; ch++)
                        sdata[ch] = cur[ch*FRAME_LEN + FRAME_LEN - 1 - bit_i];
                end
                bit_i++;
            end else begin
                bit_i = 0;
                sdata = NCH'($urandom);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [FRAME_LEN-1:0] gen_word(input bit bad_lead);
        logic [FRAME_LEN-1:0] w;
        w = FRAME_LEN'($urandom);
        if (bad_lead) w[FRAME_LEN-1 -: LEAD] = LEAD'($urandom_range(1, (1 << LEAD) - 1));
        else          w[FRAME_LEN-1 -: LEAD] = '0;
        return w;
    endfunction

    function automatic dset_t model_dout(input fset_t f);
        dset_t r;
        r = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            logic [FRAME_LEN-1:0] w;
            w = f[ch*FRAME_LEN +: FRAME_LEN];
            r[ch*DATA_W +: DATA_W] = DATA_W'(w >> (FRAME_LEN - LEAD - DATA_W));
        end
        return r;
    endfunction

    function automatic logic model_err(input fset_t f);
        for (int ch = 0; ch < NCH; ch++) begin
            logic [FRAME_LEN-1:0] w;
            w = f[ch*FRAME_LEN +: FRAME_LEN];
            if ((w >> (FRAME_LEN - LEAD)) != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (cs_n === 1'b0 && n < 64) begin
            n++;
            tick;
        end
    endtask

    task automatic wait_idle(output bit to);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick;
            n++;
        end
        to = (busy !== 1'b0);
    endtask

    task automatic run_frame(input fset_t f, output int n);
        adc_q.push_back(f);
        pulse_start;
        count_low(n);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; start = 1'b0; cont = 1'b0; ready = 1'b0;
        tick; tick;
        checks++; if (cs_n !== 1'b1)     begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
        checks++; if (dout !== '0)       begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
        checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        tick; tick;
        checks++; if (busy !== 1'b0 || cs_n !== 1'b1) begin errors++; $display("FAIL reset_idle_hold: got busy=%b cs_n=%b expected busy=0 cs_n=1", busy, cs_n); end
    endtask

    task automatic test_single;
        fset_t f;
        dset_t exp;
        int    n;
        f   = {16'h0123, 16'h0ABC};
        exp = model_dout(f);
        ready = 1'b1;
        adc_q.push_back(f);
        pulse_start;
        checks++; if (cs_n !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_start: got cs_n=%b busy=%b expected cs_n=0 busy=1", cs_n, busy); end
        count_low(n);
        checks++; if (n != FRAME_LEN)     begin errors++; $display("FAIL single_low_len: got %0d expected %0d", n, FRAME_LEN); end
        checks++; if (valid !== 1'b1)     begin errors++; $display("FAIL single_valid: got %b expected 1", valid); end
        checks++; if (dout !== exp)       begin errors++; $display("FAIL single_dout: got %h expected %h", dout, exp); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL single_frame_err: got %b expected 0", frame_err); end
        tick;
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL single_valid_drop: got %b expected 0", valid); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL single_quiet_busy: got %b expected 1", busy); end
        tick;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL single_idle: got %b expected 0", busy); end
    endtask

    task automatic test_frame_err;
        fset_t                f;
        logic [FRAME_LEN-1:0] w0;
        int                   n;
        bit                   to;
        ready = 1'b1;
        wait_idle(to);
        w0 = gen_word(1'b0);
        w0[FRAME_LEN-1 -: LEAD] = 4'b0100;
        f = {gen_word(1'b0), w0};
        run_frame(f, n);
        checks++; if (frame_err !== 1'b1)     begin errors++; $display("FAIL lead_err_set: got %b expected 1", frame_err); end
        checks++; if (dout !== model_dout(f)) begin errors++; $display("FAIL lead_err_dout: got %h expected %h", dout, model_dout(f)); end
        wait_idle(to);
        f = {gen_word(1'b0), gen_word(1'b0)};
        run_frame(f, n);
        checks++; if (frame_err !== 1'b0)     begin errors++; $display("FAIL lead_err_clear: got %b expected 0", frame_err); end
        checks++; if (dout !== model_dout(f)) begin errors++; $display("FAIL lead_clean_dout: got %h expected %h", dout, model_dout(f)); end
        for (int i = 0; i < 10; i++) begin
            wait_idle(to);
            checks++; if (to) begin errors++; $display("FAIL rand_idle_timeout: busy stuck at %b", busy); end
            f = {gen_word($urandom_range(0, 2) == 0), gen_word($urandom_range(0, 2) == 0)};
            run_frame(f, n);
            checks++; if (n != FRAME_LEN)             begin errors++; $display("FAIL rand_low_len[%0d]: got %0d expected %0d", i, n, FRAME_LEN); end
            checks++; if (dout !== model_dout(f))     begin errors++; $display("FAIL rand_dout[%0d]: got %h expected %h", i, dout, model_dout(f)); end
            checks++; if (frame_err !== model_err(f)) begin errors++; $display("FAIL rand_frame_err[%0d]: got %b expected %b", i, frame_err, model_err(f)); end
        end
    endtask

    task automatic test_overrun;
        fset_t fa, fb;
        int    n, m;
        bit    to;
        wait_idle(to);
        fa = {gen_word(1'b0), gen_word(1'b0)};
        fb = {gen_word(1'b0), gen_word(1'b1)};
        adc_q.push_back(fa);
        adc_q.push_back(fb);
        ready = 1'b0;
        cont  = 1'b1;
        tick;
        count_low(n);
        checks++; if (valid !== 1'b1 || dout !== model_dout(fa)) begin errors++; $display("FAIL ovr_first: got valid=%b dout=%h expected valid=1 dout=%h", valid, dout, model_dout(fa)); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_flag: got %b expected 0", overrun); end
        m = 0;
        while (cs_n === 1'b1 && m < 10) begin m++; tick; end
        checks++; if (m != QUIET) begin errors++; $display("FAIL ovr_quiet_len: got %0d expected %0d", m, QUIET); end
        cont = 1'b0;
        count_low(n);
        checks++; if (dout !== model_dout(fb))     begin errors++; $display("FAIL ovr_overwrite_dout: got %h expected %h", dout, model_dout(fb)); end
        checks++; if (overrun !== 1'b1)            begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        checks++; if (frame_err !== model_err(fb)) begin errors++; $display("FAIL ovr_frame_err: got %b expected %b", frame_err, model_err(fb)); end
        tick; tick; tick;
        checks++; if (valid !== 1'b1 || dout !== model_dout(fb)) begin errors++; $display("FAIL ovr_hold: got valid=%b dout=%h expected valid=1 dout=%h", valid, dout, model_dout(fb)); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL ovr_back_idle: got busy=%b expected 0", busy); end
        ready = 1'b1;
        tick;
        checks++; if (valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_accept: got valid=%b overrun=%b expected 0 0", valid, overrun); end
    endtask

    task automatic test_cont_period;
        fset_t fa, fb;
        int    n, m;
        bit    to;
        wait_idle(to);
        fa = {gen_word(1'b0), gen_word(1'b0)};
        fb = {gen_word(1'b0), gen_word(1'b0)};
        adc_q.push_back(fa);
        adc_q.push_back(fb);
        ready = 1'b1;
        cont  = 1'b1;
        tick;
        count_low(n);
        checks++; if (n != FRAME_LEN) begin errors++; $display("FAIL cont_low_len: got %0d expected %0d", n, FRAME_LEN); end
        checks++; if (valid !== 1'b1 || dout !== model_dout(fa)) begin errors++; $display("FAIL cont_first: got valid=%b dout=%h expected valid=1 dout=%h", valid, dout, model_dout(fa)); end
        m = 0;
        while (cs_n === 1'b1 && m < 10) begin m++; tick; end
        checks++; if (n + m != FRAME_LEN + QUIET) begin errors++; $display("FAIL cont_period: got %0d expected %0d", n + m, FRAME_LEN + QUIET); end
        n = 0;
        while (cs_n === 1'b0 && n < 64) begin
            if (n == 5) cont = 1'b0;
            n++;
            tick;
        end
        checks++; if (n != FRAME_LEN) begin errors++; $display("FAIL cont_drop_len: got %0d expected %0d", n, FRAME_LEN); end
        checks++; if (valid !== 1'b1 || dout !== model_dout(fb)) begin errors++; $display("FAIL cont_second: got valid=%b dout=%h expected valid=1 dout=%h", valid, dout, model_dout(fb)); end
        m = 0;
        while (cs_n === 1'b1 && m < 10) begin m++; tick; end
        checks++; if (m != 10)        begin errors++; $display("FAIL cont_stop: got %0d high cycles expected %0d", m, 10); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL cont_stop_busy: got %b expected 0", busy); end
    endtask

    task automatic test_start_ignored;
        fset_t fa, fb;
        int    n;
        bit    to;
        wait_idle(to);
        fa = {gen_word(1'b0), gen_word(1'b0)};
        fb = {gen_word(1'b1), gen_word(1'b0)};
        ready = 1'b1;
        adc_q.push_back(fa);
        pulse_start;
        n = 0;
        while (cs_n === 1'b0 && n < 64) begin
            start = (n == 3);
            n++;
            tick;
        end
        start = 1'b0;
        checks++; if (n != FRAME_LEN)         begin errors++; $display("FAIL ign_low_len: got %0d expected %0d", n, FRAME_LEN); end
        checks++; if (dout !== model_dout(fa)) begin errors++; $display("FAIL ign_dout: got %h expected %h", dout, model_dout(fa)); end
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++; if (busy !== 1'b0 || cs_n !== 1'b1) begin errors++; $display("FAIL ign_quiet_start: got busy=%b cs_n=%b expected busy=0 cs_n=1", busy, cs_n); end
        adc_q.push_back(fb);
        pulse_start;
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL earliest_start: got cs_n=%b expected 0", cs_n); end
        count_low(n);
        checks++; if (dout !== model_dout(fb) || frame_err !== 1'b1) begin errors++; $display("FAIL earliest_frame: got dout=%h err=%b expected dout=%h err=1", dout, frame_err, model_dout(fb)); end
    endtask

    task automatic test_back_to_back;
        fset_t fa, fb, fc;
        int    n;
        bit    to;
        wait_idle(to);
        ready = 1'b0;
        fa = {gen_word(1'b0), gen_word(1'b0)};
        fb = {gen_word(1'b0), gen_word(1'b0)};
        fc = {gen_word(1'b1), gen_word(1'b0)};
        run_frame(fa, n);
        wait_idle(to);
        run_frame(fb, n);
        checks++; if (overrun !== 1'b1 || dout !== model_dout(fb)) begin errors++; $display("FAIL b2b_overrun: got ovr=%b dout=%h expected ovr=1 dout=%h", overrun, dout, model_dout(fb)); end
        wait_idle(to);
        adc_q.push_back(fc);
        pulse_start;
        for (int i = 0; i < FRAME_LEN - 1; i++) tick;
        checks++; if (cs_n !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL b2b_pre: got cs_n=%b valid=%b expected 0 1", cs_n, valid); end
        ready = 1'b1;
        tick;
        checks++; if (dout !== model_dout(fc)) begin errors++; $display("FAIL b2b_dout: got %h expected %h", dout, model_dout(fc)); end
        checks++; if (valid !== 1'b1)          begin errors++; $display("FAIL b2b_valid: got %b expected 1", valid); end
        checks++; if (overrun !== 1'b0)        begin errors++; $display("FAIL b2b_overrun_clr: got %b expected 0", overrun); end
        checks++; if (frame_err !== 1'b1)      begin errors++; $display("FAIL b2b_frame_err: got %b expected 1", frame_err); end
        tick;
        checks++; if (valid !== 1'b0)          begin errors++; $display("FAIL b2b_accept: got %b expected 0", valid); end
    endtask

    task automatic test_reset_mid;
        fset_t fa, fb, fc;
        int    n;
        bit    to;
        wait_idle(to);
        ready = 1'b0;
        fa = {gen_word(1'b0), gen_word(1'b0)};
        fa[0] = 1'b1;
        fa[FRAME_LEN-LEAD-1] = 1'b1;
        fb = {gen_word(1'b1), gen_word(1'b1)};
        fc = {gen_word(1'b0), gen_word(1'b0)};
        run_frame(fa, n);
        checks++; if (valid !== 1'b1 || dout !== model_dout(fa)) begin errors++; $display("FAIL rstmid_pre: got valid=%b dout=%h expected valid=1 dout=%h", valid, dout, model_dout(fa)); end
        wait_idle(to);
        adc_q.push_back(fb);
        pulse_start;
        for (int i = 0; i < 8; i++) tick;
        rst = 1'b1;
        #1;
        checks++; if (cs_n !== 1'b1)  begin errors++; $display("FAIL rstmid_cs_n: got %b expected 1", cs_n); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", valid); end
        checks++; if (dout !== '0)    begin errors++; $display("FAIL rstmid_dout: got %h expected 0", dout); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        tick; tick;
        rst = 1'b0;
        tick;
        ready = 1'b1;
        run_frame(fc, n);
        checks++; if (n != FRAME_LEN)         begin errors++; $display("FAIL rstmid_low_len: got %0d expected %0d", n, FRAME_LEN); end
        checks++; if (dout !== model_dout(fc)) begin errors++; $display("FAIL rstmid_dout_after: got %h expected %h", dout, model_dout(fc)); end
        checks++; if (frame_err !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL rstmid_flags: got err=%b valid=%b expected 0 1", frame_err, valid); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL rstmid_idle_timeout: busy stuck at %b", busy); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        cont  = 1'b0;
        ready = 1'b0;
        test_reset;
        test_single;
        test_frame_err;
        test_overrun;
        test_cont_period;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
